// File: rtl/imem_loader_pkg.sv
// Shared pipeline constants for the instruction-memory loader and the fetch stage.
package imem_loader_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam int FETCH_BYTES = 10;

  localparam logic [3:0] HALT_ICODE = 4'h0;
  // Unloaded space must decode as halt with ifun 0.
  localparam logic [7:0] HALT_BYTE  = {HALT_ICODE, 4'h0};
endpackage

// File: rtl/imem_bytes.sv
// Byte-wide program store: one synchronous write port, FETCH_BYTES combinational read ports.
module imem_bytes
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic                                  clk,
  input  logic                                  we,
  input  logic [ADDR_W-1:0]                     waddr,
  input  logic [7:0]                            wdata,
  input  logic [FETCH_BYTES-1:0][ADDR_W-1:0]    raddr,
  output logic [FETCH_BYTES-1:0][7:0]           rdata
);
  logic [7:0] mem [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  for (genvar k = 0; k < FETCH_BYTES; k++) begin : g_rd
    assign rdata[k] = mem[raddr[k]];
  end
endmodule

// File: rtl/imem_loader.sv
// Loads a program over valid/ready, then serves a masked 10-byte fetch window to the pipeline.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic [ADDR_W:0]   ld_count,
  output logic              ld_error,
  output logic              cpu_go,
  input  logic [63:0]       f_pc,
  output logic [79:0]       f_bytes,
  output logic              f_imem_error
);
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  logic [1:0]      state_q, state_d;
  logic [ADDR_W:0] ld_count_q, ld_count_d;
  logic            offer, full, wr_en;

  logic [FETCH_BYTES-1:0][ADDR_W-1:0] raddr;
  logic [FETCH_BYTES-1:0][7:0]        rdata;
  logic [64:0]                        wmark;

  // ld_ready is held low while reset is asserted, not just once the state settles.
  assign ld_ready = rst_n && (state_q == ST_IDLE || state_q == ST_LOAD);
  assign offer    = ld_valid && ld_ready;
  assign full     = (ld_count_q == MEM_LIMIT);
  assign wr_en    = offer && !full;

  always_comb begin
    state_d    = state_q;
    ld_count_d = ld_count_q;
    if ((state_q == ST_IDLE || state_q == ST_LOAD) && offer) begin
      if (full) begin
        state_d = ST_ERR;
      end else begin
        ld_count_d = ld_count_q + 1'b1;
        state_d    = ld_last ? ST_RUN : ST_LOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ld_count_q <= '0;
    end else begin
      state_q    <= state_d;
      ld_count_q <= ld_count_d;
    end
  end

  assign ld_count = ld_count_q;
  assign ld_error = (state_q == ST_ERR);
  assign cpu_go   = (state_q == ST_RUN);

  imem_bytes #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (ld_count_q[ADDR_W-1:0]),
    .wdata (ld_byte),
    .raddr (raddr),
    .rdata (rdata)
  );

  // 65-bit addresses so f_pc near 2^64 cannot wrap back into the program.
  assign wmark = 65'(ld_count_q);

  for (genvar k = 0; k < FETCH_BYTES; k++) begin : g_fetch
    logic [64:0] addr;
    logic        in_rng;
    assign addr               = {1'b0, f_pc} + 65'(k);
    assign in_rng             = addr < wmark;
    assign raddr[k]           = addr[ADDR_W-1:0];
    assign f_bytes[8*k +: 8]  = (cpu_go && in_rng) ? rdata[k] : HALT_BYTE;
  end

  assign f_imem_error = cpu_go && ({1'b0, f_pc} >= wmark);
endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a simple program-array model.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_valid = 1'b0, ld_last = 1'b0, ld_ready, ld_error, cpu_go, f_imem_error;
  logic [7:0]  ld_byte = 8'h00;
  logic [10:0] ld_count;
  logic [63:0] f_pc = 64'd0;
  logic [79:0] f_bytes;

  logic        s_valid = 1'b0, s_last = 1'b0, s_ready, s_error, s_go, s_ferr;
  logic [7:0]  s_byte = 8'h00;
  logic [4:0]  s_count;
  logic [63:0] s_pc = 64'd0;
  logic [79:0] s_bytes;

  int errors = 0;
  int checks = 0;

  // Reference model: the program as a plain byte array plus load status.
  logic [7:0] mprog [1024];
  int         mcount;
  bit         mrun, merr;

  always #5 clk = ~clk;

  imem_loader #(.MEM_BYTES(1024), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_byte(ld_byte),
    .ld_last(ld_last), .ld_count(ld_count), .ld_error(ld_error), .cpu_go(cpu_go),
    .f_pc(f_pc), .f_bytes(f_bytes), .f_imem_error(f_imem_error));

  imem_loader #(.MEM_BYTES(16), .ADDR_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .ld_valid(s_valid), .ld_ready(s_ready), .ld_byte(s_byte),
    .ld_last(s_last), .ld_count(s_count), .ld_error(s_error), .cpu_go(s_go),
    .f_pc(s_pc), .f_bytes(s_bytes), .f_imem_error(s_ferr));

  function automatic logic [79:0] exp_window(input logic [63:0] pc);
    logic [79:0] r;
    logic [64:0] a;
    r = '0;
    if (mrun)
      for (int k = 0; k < 10; k++) begin
        a = {1'b0, pc} + 65'(k);
        if (a < 65'(mcount)) r[8*k +: 8] = mprog[a[9:0]];
      end
    return r;
  endfunction

  task automatic do_reset();
    ld_valid = 0; ld_last = 0; s_valid = 0; s_last = 0;
    #3 rst_n = 0;
    #7 rst_n = 1;
    mcount = 0; mrun = 0; merr = 0;
    @(posedge clk); #1;
  endtask

  // One cycle of loader traffic: check ready before the edge, update model, check after.
  task automatic step(input bit v, input logic [7:0] b, input bit l);
    bit rdy;
    ld_valid = v; ld_byte = b; ld_last = l;
    @(negedge clk);
    rdy = !mrun && !merr;
    checks++;
    if (ld_ready !== rdy) begin
      errors++; $display("FAIL step_ready: got %b want %b", ld_ready, rdy);
    end
    checks++;
    if (cpu_go !== mrun) begin
      errors++; $display("FAIL step_go_pre: got %b want %b", cpu_go, mrun);
    end
    @(posedge clk);
    if (v && rdy) begin
      if (mcount == 1024) merr = 1;
      else begin
        mprog[mcount] = b; mcount++;
        if (l) mrun = 1;
      end
    end
    #1;
    ld_valid = 0; ld_last = 0;
    checks++;
    if (ld_count !== 11'(mcount) || cpu_go !== mrun || ld_error !== merr) begin
      errors++;
      $display("FAIL step_state: count=%0d go=%b err=%b want count=%0d go=%b err=%b",
               ld_count, cpu_go, ld_error, mcount, mrun, merr);
    end
  endtask

  task automatic check_fetch(input logic [63:0] pc, input string nm);
    logic [79:0] eb;
    bit          ee;
    f_pc = pc; #1;
    eb = exp_window(pc);
    ee = mrun && ({1'b0, pc} >= 65'(mcount));
    checks++;
    if (f_bytes !== eb || f_imem_error !== ee) begin
      errors++;
      $display("FAIL %s pc=%h: bytes=%h err=%b want bytes=%h err=%b", nm, pc, f_bytes,
               f_imem_error, eb, ee);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; #2;
    checks++;
    if (ld_ready !== 0 || ld_count !== 0 || ld_error !== 0 || cpu_go !== 0 ||
        f_bytes !== 0 || f_imem_error !== 0) begin
      errors++; $display("FAIL reset_outputs: ready=%b count=%0d err=%b go=%b bytes=%h ferr=%b want all 0",
                         ld_ready, ld_count, ld_error, cpu_go, f_bytes, f_imem_error);
    end
    do_reset();
    checks++;
    if (ld_ready !== 1'b1) begin
      errors++; $display("FAIL reset_idle_ready: got %b want 1", ld_ready);
    end
  endtask

  task automatic test_irmovq();
    logic [7:0] prog [11];
    prog = '{8'h30, 8'hF0, 8'h05, 0, 0, 0, 0, 0, 0, 0, 8'h00};
    do_reset();
    for (int i = 0; i < 11; i++) step(1, prog[i], i == 10);
    checks++;
    if (ld_count !== 11'd11 || cpu_go !== 1'b1) begin
      errors++; $display("FAIL irmovq_done: count=%0d go=%b want 11 1", ld_count, cpu_go);
    end
    f_pc = 0; #1;
    checks++;
    if (f_bytes !== 80'h0000000000000005F030 || f_imem_error !== 1'b0) begin
      errors++; $display("FAIL irmovq_pc0: bytes=%h err=%b want 0000000000000005f030 0",
                         f_bytes, f_imem_error);
    end
    check_fetch(64'd8, "irmovq_pc8");
    check_fetch(64'd10, "irmovq_pc10");
    f_pc = 64'd11; #1;
    checks++;
    if (f_bytes !== 80'd0 || f_imem_error !== 1'b1) begin
      errors++; $display("FAIL irmovq_pc11: bytes=%h err=%b want 0 1", f_bytes, f_imem_error);
    end
  endtask

  task automatic test_gaps();
    int cyc = 0;
    bit v;
    do_reset();
    while (!mrun && cyc < 200) begin
      v = 1'($urandom);
      step(v, 8'($urandom), v && mcount == 19);
      cyc++;
    end
    checks++;
    if (!mrun) begin
      errors++; $display("FAIL gaps_timeout: loaded %0d of 20 bytes", mcount);
    end
    for (int p = 0; p < 24; p++) check_fetch(64'(p), "gaps_fetch");
    for (int i = 0; i < 3; i++) step(1, 8'hAA, 0);
  endtask

  task automatic test_reset_midload();
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0);
    f_pc = 0;
    #3 rst_n = 0;
    #1;
    checks++;
    if (ld_ready !== 0 || ld_count !== 0 || ld_error !== 0 || cpu_go !== 0 ||
        f_bytes !== 0 || f_imem_error !== 0) begin
      errors++; $display("FAIL midload_reset: ready=%b count=%0d go=%b bytes=%h want all 0",
                         ld_ready, ld_count, cpu_go, f_bytes);
    end
    #4 rst_n = 1;
    mcount = 0; mrun = 0; merr = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step(1, 8'($urandom_range(1, 255)), i == 2);
    checks++;
    if (ld_count !== 11'd3) begin
      errors++; $display("FAIL midload_count: got %0d want 3", ld_count);
    end
    for (int p = 0; p < 10; p++) check_fetch(64'(p), "midload_fetch");
  endtask

  task automatic test_large_pc();
    check_fetch(64'h1_0000_0000, "large_pc_4g");
    check_fetch(64'd1024, "large_pc_1024");
    check_fetch(64'hFFFF_FFFF_FFFF_FFFF, "large_pc_max");
    check_fetch(64'h8000_0000_0000_0001, "large_pc_top");
    for (int i = 0; i < 8; i++) check_fetch({$urandom, $urandom}, "large_pc_rand");
  endtask

  task automatic test_overflow();
    logic [7:0] b [17];
    do_reset();
    for (int i = 0; i < 17; i++) b[i] = 8'($urandom);
    b[16] = ~b[0];
    for (int i = 0; i < 17; i++) begin
      s_valid = 1; s_byte = b[i]; s_last = 0;
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b1) begin
        errors++; $display("FAIL ovf_ready: byte %0d got %b want 1", i, s_ready);
      end
      @(posedge clk); #1;
    end
    s_valid = 0;
    checks++;
    if (s_count !== 5'd16 || s_error !== 1'b1 || s_go !== 1'b0 || s_ready !== 1'b0) begin
      errors++; $display("FAIL ovf_state: count=%0d err=%b go=%b ready=%b want 16 1 0 0",
                         s_count, s_error, s_go, s_ready);
    end
    checks++;
    if (dut_s.u_mem.mem[0] !== b[0]) begin
      errors++; $display("FAIL ovf_nowrite: mem0=%h want %h", dut_s.u_mem.mem[0], b[0]);
    end
    s_valid = 1; @(posedge clk); #1; s_valid = 0;
    checks++;
    if (s_count !== 5'd16 || s_error !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: count=%0d err=%b want 16 1", s_count, s_error);
    end
  endtask

  task automatic test_full_last();
    logic [7:0] b [16];
    do_reset();
    for (int i = 0; i < 16; i++) begin
      b[i] = 8'($urandom);
      s_valid = 1; s_byte = b[i]; s_last = (i == 15);
      @(posedge clk); #1;
    end
    s_valid = 0; s_last = 0;
    s_pc = 64'd15; #1;
    checks++;
    if (s_count !== 5'd16 || s_go !== 1'b1 || s_error !== 1'b0 ||
        s_bytes !== {72'd0, b[15]} || s_ferr !== 1'b0) begin
      errors++; $display("FAIL full_last: count=%0d go=%b err=%b bytes=%h ferr=%b want 16 1 0 %h 0",
                         s_count, s_go, s_error, s_bytes, s_ferr, b[15]);
    end
    s_pc = 64'd16; #1;
    checks++;
    if (s_bytes !== 80'd0 || s_ferr !== 1'b1) begin
      errors++; $display("FAIL full_pc16: bytes=%h ferr=%b want 0 1", s_bytes, s_ferr);
    end
  endtask

  initial begin
    mcount = 0; mrun = 0; merr = 0;
    test_reset();
    test_irmovq();
    test_gaps();
    test_large_pc();
    test_reset_midload();
    test_overflow();
    test_full_last();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
